// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac_feeder / mac pair.
//   - state_e    : feeder FSM state encoding
//   - n_is_legal : only N=127 (16 elements) and N=511 (64 elements) are supported
//   - cnt_msb    : MSB index M of the element counter for a given N
//   - elem_count : number of byte elements E=(N+1)/8 for a given N
package mac_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

    function automatic bit n_is_legal(input int n);
        return (n == 127) || (n == 511);
    endfunction

    function automatic int cnt_msb(input int n);
        return (n == 127) ? 3 : 5;
    endfunction

    function automatic int elem_count(input int n);
        return (n + 1) / 8;
    endfunction

endpackage

// File: rtl/mac_feeder.sv
// mac_feeder: front-end sequencer for the mac dot-product stage.
// Collects E operand byte pairs into two packed vectors, walks the element
// index cnt through 0..E-1 while presenting the operands, then captures the
// MAC result and offers it on a valid/ready output stream.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand pair handshake; in_a/in_b are the bytes
//   regA, regB          packed operand vectors (element i at [8i+7:8i]),
//                       zero outside RUN
//   cnt                 element index to the MAC
//   mac_clr             drives the MAC's reset; high while loading
//   mac_res             MAC result
//   out_valid/out_ready result handshake; out_data is the captured result
module mac_feeder
    import mac_pkg::*;
#(
    parameter int N = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_a,
    input  logic [7:0]            in_b,
    output logic [N:0]            regA,
    output logic [N:0]            regB,
    output logic [cnt_msb(N):0]   cnt,
    output logic                  mac_clr,
    input  logic [7:0]            mac_res,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready
);

    localparam int M = cnt_msb(N);
    localparam int E = elem_count(N);
    localparam logic [M:0] LAST_IDX = (M + 1)'(E - 1);

    if (!n_is_legal(N)) begin : g_bad_n
        $error("mac_feeder: N must be 127 or 511");
    end

    state_e       state_q,     state_d;
    logic [M:0]   load_idx_q,  load_idx_d;
    logic [M:0]   cnt_q,       cnt_d;
    logic         mac_clr_q,   mac_clr_d;
    logic         op_en_q,     op_en_d;
    logic         in_ready_q,  in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   out_data_q,  out_data_d;
    logic [N:0]   vec_a_q,     vec_a_d;
    logic [N:0]   vec_b_q,     vec_b_d;

    // All state and control outputs are flops; mac_clr in particular feeds
    // the MAC's asynchronous reset and must never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_idx_q  <= '0;
            cnt_q       <= '0;
            mac_clr_q   <= 1'b1;
            op_en_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            vec_a_q     <= '0;
            vec_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            cnt_q       <= cnt_d;
            mac_clr_q   <= mac_clr_d;
            op_en_q     <= op_en_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            vec_a_q     <= vec_a_d;
            vec_b_q     <= vec_b_d;
        end
    end

    // Next-state and next-output decode for the LOAD/RUN/CAPTURE/OUT sequence.
    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        cnt_d       = cnt_q;
        mac_clr_d   = mac_clr_q;
        op_en_d     = op_en_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        vec_a_d     = vec_a_q;
        vec_b_d     = vec_b_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    vec_a_d[{load_idx_q, 3'b000} +: 8] = in_a;
                    vec_b_d[{load_idx_q, 3'b000} +: 8] = in_b;
                    if (load_idx_q == LAST_IDX) begin
                        // Last element: release the MAC and start walking cnt.
                        load_idx_d = '0;
                        state_d    = ST_RUN;
                        mac_clr_d  = 1'b0;
                        op_en_d    = 1'b1;
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                    end else begin
                        load_idx_d = load_idx_q + (M + 1)'(1);
                    end
                end else begin
                    load_idx_d = load_idx_q;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_CAPTURE;
                    op_en_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + (M + 1)'(1);
                end
            end
            ST_CAPTURE: begin
                // Operands are gated to zero here, so mac_res is settled.
                out_data_d  = mac_res;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                    mac_clr_d   = 1'b1;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                load_idx_d  = '0;
                cnt_d       = '0;
                mac_clr_d   = 1'b1;
                op_en_d     = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign regA      = vec_a_q & {(N + 1){op_en_q}};
    assign regB      = vec_b_q & {(N + 1){op_en_q}};
    assign cnt       = cnt_q;
    assign mac_clr   = mac_clr_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
